// File: rtl/sram_rw_ctrl_pkg.sv
// ============================================================================
// sram_ctrl_pkg : shared widths, FSM state and write-request type for the
//                 sram_rw_ctrl controller slice.
// Revision: 1.0
// ============================================================================
`default_nettype none

package sram_ctrl_pkg;

  localparam int unsigned ADDR_W_DEF = 12;
  localparam int unsigned LANES_DEF  = 10;
  localparam int unsigned LANE_W_DEF = 6;

  function automatic int unsigned data_w(input int unsigned lanes, input int unsigned lane_w);
    return lanes * lane_w;
  endfunction

  localparam int unsigned DATA_W_DEF = data_w(LANES_DEF, LANE_W_DEF);

  typedef enum logic [0:0] {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_e;

  typedef struct packed {
    logic [ADDR_W_DEF-1:0] addr;
    logic [LANES_DEF-1:0]  mask;
    logic [DATA_W_DEF-1:0] data;
  } wr_req_t;

endpackage

`default_nettype wire

// File: rtl/sram_rw_ctrl_if.sv
// ============================================================================
// sram_rw_ctrl_if : client request/response channels plus SRAM macro pins.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface sram_rw_ctrl_if
  import sram_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned LANES  = LANES_DEF,
  parameter int unsigned LANE_W = LANE_W_DEF
);
  localparam int unsigned DATA_W = data_w(LANES, LANE_W);

  logic              w_valid;
  logic              w_ready;
  logic [ADDR_W-1:0] w_addr;
  logic [LANES-1:0]  w_mask;
  logic [DATA_W-1:0] w_data;
  logic              r_valid;
  logic              r_ready;
  logic [ADDR_W-1:0] r_addr;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_data;
  logic              init_done;
  logic              sram_en;
  logic              sram_wmode;
  logic [ADDR_W-1:0] sram_addr;
  logic [LANES-1:0]  sram_wmask;
  logic [DATA_W-1:0] sram_wdata;
  logic [DATA_W-1:0] sram_rdata;

  modport slave (
    input  w_valid, w_addr, w_mask, w_data, r_valid, r_addr, sram_rdata,
    output w_ready, r_ready, resp_valid, resp_data, init_done,
           sram_en, sram_wmode, sram_addr, sram_wmask, sram_wdata
  );

  modport master (
    output w_valid, w_addr, w_mask, w_data, r_valid, r_addr, sram_rdata,
    input  w_ready, r_ready, resp_valid, resp_data, init_done,
           sram_en, sram_wmode, sram_addr, sram_wmask, sram_wdata
  );

endinterface

`default_nettype wire

// File: rtl/sram_rw_ctrl_lane_merge.sv
// ============================================================================
// sram_lane_merge : per-lane select between buffered write data and SRAM data.
// Revision: 1.0
// ============================================================================
`default_nettype none

module sram_lane_merge
  import sram_ctrl_pkg::*;
#(
  parameter int unsigned LANES  = LANES_DEF,
  parameter int unsigned LANE_W = LANE_W_DEF
) (
  input  logic [LANES-1:0]        sel_i,
  input  logic [LANES*LANE_W-1:0] buf_data_i,
  input  logic [LANES*LANE_W-1:0] sram_data_i,
  output logic [LANES*LANE_W-1:0] merged_o
);

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    assign merged_o[i*LANE_W +: LANE_W] = sel_i[i] ? buf_data_i[i*LANE_W +: LANE_W]
                                                   : sram_data_i[i*LANE_W +: LANE_W];
  end

endmodule

`default_nettype wire

// File: rtl/sram_rw_ctrl.sv
// ============================================================================
// sram_rw_ctrl : single-port lane-masked SRAM controller with zero-init sweep
//                and read-data hold. SRAM_RW_CTRL_WBUF_EN adds a 1-entry
//                write buffer with read priority and buffer-to-read merging.
// Revision: 1.0
// ============================================================================
`default_nettype none

module sram_rw_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W    = ADDR_W_DEF,
  parameter int unsigned LANES     = LANES_DEF,
  parameter int unsigned LANE_W    = LANE_W_DEF,
  parameter int unsigned INIT_ZERO = 1
) (
  input  logic          clock,
  input  logic          reset,
  sram_rw_ctrl_if.slave ctrl_if
);

  localparam int unsigned DATA_W    = data_w(LANES, LANE_W);
  localparam state_e      RST_STATE = (INIT_ZERO != 0) ? INIT : RUN;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              sweep_en, run_en;
  logic              w_ready, r_ready, w_acc, rd_acc;
  logic              mac_wr;
  wr_req_t           in_req, mac_req;
  logic              mac_en, mac_wmode;
  logic [ADDR_W-1:0] mac_addr;
  logic [LANES-1:0]  mac_wmask;
  logic [DATA_W-1:0] mac_wdata;
  logic              rd_pend_q;
  logic [DATA_W-1:0] hold_q, rdata_eff, resp_data;
  logic              resp_valid;

  assign in_req = '{addr: ctrl_if.w_addr, mask: ctrl_if.w_mask, data: ctrl_if.w_data};

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sweep_en = 1'b0;
    run_en   = 1'b0;
    unique case (state_q)
      INIT: begin
        sweep_en = ~reset;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == '1) state_d = RUN;
      end
      RUN:     run_en  = ~reset;
      default: state_d = RST_STATE;
    endcase
  end

`ifdef SRAM_RW_CTRL_WBUF_EN
  wr_req_t           wb_q, wb_d;
  logic              wb_valid_q, wb_valid_d;
  logic              mrg_hit_q;
  logic [LANES-1:0]  mrg_mask_q, mrg_sel;
  logic [DATA_W-1:0] mrg_data_q;

  assign r_ready = run_en;
  assign rd_acc  = ctrl_if.r_valid & r_ready;
  assign w_ready = run_en & (~wb_valid_q | ~rd_acc);
  assign w_acc   = ctrl_if.w_valid & w_ready;
  // An older buffered write always reaches the macro before a newer one.
  assign mac_wr  = run_en & ~rd_acc & (wb_valid_q | w_acc);
  assign mac_req = wb_valid_q ? wb_q : in_req;

  always_comb begin
    wb_d       = wb_q;
    wb_valid_d = wb_valid_q;
    if (mac_wr && wb_valid_q) wb_valid_d = 1'b0;
    if (w_acc && (rd_acc || wb_valid_q)) begin
      wb_d       = in_req;
      wb_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wb_valid_q <= 1'b0;
      mrg_hit_q  <= 1'b0;
    end else begin
      wb_valid_q <= wb_valid_d;
      mrg_hit_q  <= rd_acc & wb_valid_q & (wb_q.addr == ctrl_if.r_addr);
    end
  end

  always_ff @(posedge clock) begin
    wb_q <= wb_d;
    if (rd_acc) begin
      mrg_mask_q <= wb_q.mask;
      mrg_data_q <= wb_q.data;
    end
  end

  assign mrg_sel = mrg_hit_q ? mrg_mask_q : '0;

  sram_lane_merge #(
    .LANES  (LANES),
    .LANE_W (LANE_W)
  ) u_lane_merge (
    .sel_i       (mrg_sel),
    .buf_data_i  (mrg_data_q),
    .sram_data_i (ctrl_if.sram_rdata),
    .merged_o    (rdata_eff)
  );
`else
  assign w_ready   = run_en;
  assign r_ready   = run_en & ~ctrl_if.w_valid;
  assign w_acc     = ctrl_if.w_valid & w_ready;
  assign rd_acc    = ctrl_if.r_valid & r_ready;
  assign mac_wr    = w_acc;
  assign mac_req   = in_req;
  assign rdata_eff = ctrl_if.sram_rdata;
`endif

  always_comb begin
    mac_en    = 1'b0;
    mac_wmode = 1'b0;
    mac_addr  = ctrl_if.r_addr;
    mac_wmask = '0;
    mac_wdata = '0;
    if (sweep_en) begin
      mac_en    = 1'b1;
      mac_wmode = 1'b1;
      mac_addr  = cnt_q;
      mac_wmask = '1;
    end else if (mac_wr) begin
      mac_en    = 1'b1;
      mac_wmode = 1'b1;
      mac_addr  = mac_req.addr;
      mac_wmask = mac_req.mask;
      mac_wdata = mac_req.data;
    end else if (rd_acc) begin
      mac_en    = 1'b1;
    end
  end

  // Response outputs are forced to their reset values while reset is high.
  assign resp_valid = rd_pend_q & ~reset;
  assign resp_data  = reset ? '0 : (resp_valid ? rdata_eff : hold_q);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= RST_STATE;
      cnt_q     <= '0;
      rd_pend_q <= 1'b0;
      hold_q    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rd_pend_q <= rd_acc;
      if (resp_valid) hold_q <= resp_data;
    end
  end

  assign ctrl_if.w_ready    = w_ready;
  assign ctrl_if.r_ready    = r_ready;
  assign ctrl_if.init_done  = run_en;
  assign ctrl_if.resp_valid = resp_valid;
  assign ctrl_if.resp_data  = resp_data;
  assign ctrl_if.sram_en    = mac_en;
  assign ctrl_if.sram_wmode = mac_wmode;
  assign ctrl_if.sram_addr  = mac_addr;
  assign ctrl_if.sram_wmask = mac_wmask;
  assign ctrl_if.sram_wdata = mac_wdata;

endmodule

`default_nettype wire

// File: tb/tb_sram_rw_ctrl.sv
// ============================================================================
// tb_sram_rw_ctrl : SRAM macro model plus a memory-level reference model of the
//                   controller, checked every cycle on the falling edge.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_sram_rw_ctrl;
  import sram_ctrl_pkg::*;

  localparam int unsigned AW    = 12;
  localparam int unsigned LN    = 10;
  localparam int unsigned LW    = 6;
  localparam int unsigned DW    = 60;
  localparam int          DEPTH = 4096;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  sram_rw_ctrl_if #(.ADDR_W(AW), .LANES(LN), .LANE_W(LW)) bus ();

  sram_rw_ctrl #(
    .ADDR_W    (AW),
    .LANES     (LN),
    .LANE_W    (LW),
    .INIT_ZERO (1)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .ctrl_if (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] rnd60();
    logic [63:0] t;
    t = {$urandom(), $urandom()};
    return t[DW-1:0];
  endfunction

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [LN-1:0] m,
                                          input logic [DW-1:0] d);
    logic [DW-1:0] r;
    r = old;
    for (int l = 0; l < LN; l++) if (m[l]) r[l*LW +: LW] = d[l*LW +: LW];
    return r;
  endfunction

  // ---------------- SRAM macro: 1-cycle read latency, junk outside window
  logic [DW-1:0] mem [DEPTH];
  logic          rd_q = 1'b0;
  logic [DW-1:0] rdq_data = '0;
  logic [DW-1:0] junk = '0;

  initial for (int i = 0; i < DEPTH; i++) mem[i] = rnd60();

  always @(posedge clock) begin
    junk <= rnd60();
    rd_q <= bus.sram_en && !bus.sram_wmode;
    if (bus.sram_en) begin
      if (bus.sram_wmode) mem[bus.sram_addr] <= merge(mem[bus.sram_addr], bus.sram_wmask, bus.sram_wdata);
      else                rdq_data <= mem[bus.sram_addr];
    end
  end
  assign bus.sram_rdata = rd_q ? rdq_data : junk;

  // ---------------- reference model: client-visible memory and responses
  logic [DW-1:0] ref_mem [DEPTH];
  int            m_cyc = 0;
  bit            m_pend = 0, m_full = 0;
  logic [DW-1:0] m_pend_data = '0, m_hold = '0;
  bit            mrun, er, ew, mracc, mwacc;

  always @(negedge clock) begin
    if (reset) begin
      chk("rst_w_ready", 64'(bus.w_ready), 64'd0);
      chk("rst_r_ready", 64'(bus.r_ready), 64'd0);
      chk("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
      chk("rst_resp_data", 64'(bus.resp_data), 64'd0);
      chk("rst_init_done", 64'(bus.init_done), 64'd0);
      chk("rst_sram_en", 64'(bus.sram_en), 64'd0);
      m_cyc  = 0;
      m_pend = 0;
      m_hold = '0;
      m_full = 0;
    end else begin
      mrun = (m_cyc >= DEPTH);
`ifdef SRAM_RW_CTRL_WBUF_EN
      er    = mrun;
      mracc = bus.r_valid && er;
      ew    = mrun && (!m_full || !mracc);
`else
      ew    = mrun;
      er    = mrun && !bus.w_valid;
      mracc = bus.r_valid && er;
`endif
      mwacc = bus.w_valid && ew;
      chk("init_done", 64'(bus.init_done), 64'(mrun));
      chk("w_ready", 64'(bus.w_ready), 64'(ew));
      chk("r_ready", 64'(bus.r_ready), 64'(er));
      chk("resp_valid", 64'(bus.resp_valid), 64'(m_pend));
      chk("resp_data", 64'(bus.resp_data), 64'(m_pend ? m_pend_data : m_hold));
      if (m_pend) m_hold = m_pend_data;
      if (!mrun) begin
        chk("sweep_en", 64'(bus.sram_en), 64'd1);
        chk("sweep_wmode", 64'(bus.sram_wmode), 64'd1);
        chk("sweep_addr", 64'(bus.sram_addr), 64'(m_cyc));
        chk("sweep_mask", 64'(bus.sram_wmask), 64'h3FF);
        chk("sweep_data", 64'(bus.sram_wdata), 64'd0);
        ref_mem[m_cyc] = '0;
        m_cyc++;
      end else begin
`ifdef SRAM_RW_CTRL_WBUF_EN
        if (mracc) begin
          chk("rd_en", 64'(bus.sram_en), 64'd1);
          chk("rd_wmode", 64'(bus.sram_wmode), 64'd0);
          chk("rd_addr", 64'(bus.sram_addr), 64'(bus.r_addr));
        end else if (m_full || mwacc) begin
          chk("wr_en", 64'(bus.sram_en), 64'd1);
          chk("wr_wmode", 64'(bus.sram_wmode), 64'd1);
        end else begin
          chk("idle_en", 64'(bus.sram_en), 64'd0);
        end
        m_full = mracc ? (m_full || mwacc) : (m_full && mwacc);
`else
        if (mwacc) begin
          chk("wr_en", 64'(bus.sram_en), 64'd1);
          chk("wr_wmode", 64'(bus.sram_wmode), 64'd1);
          chk("wr_addr", 64'(bus.sram_addr), 64'(bus.w_addr));
          chk("wr_mask", 64'(bus.sram_wmask), 64'(bus.w_mask));
          chk("wr_data", 64'(bus.sram_wdata), 64'(bus.w_data));
        end else if (mracc) begin
          chk("rd_en", 64'(bus.sram_en), 64'd1);
          chk("rd_wmode", 64'(bus.sram_wmode), 64'd0);
          chk("rd_addr", 64'(bus.sram_addr), 64'(bus.r_addr));
        end else begin
          chk("idle_en", 64'(bus.sram_en), 64'd0);
        end
`endif
      end
      // A read sees memory as it stood before any write accepted alongside it.
      m_pend = mracc;
      if (mracc) m_pend_data = ref_mem[bus.r_addr];
      if (mwacc) ref_mem[bus.w_addr] = merge(ref_mem[bus.w_addr], bus.w_mask, bus.w_data);
    end
  end

  // ---------------- stimulus
  task automatic step(input bit wv, input logic [AW-1:0] wad, input logic [LN-1:0] wm,
                      input logic [DW-1:0] wd, input bit rv, input logic [AW-1:0] rad,
                      output bit wacc, output bit racc);
    bus.w_valid = wv;
    bus.w_addr  = wad;
    bus.w_mask  = wm;
    bus.w_data  = wd;
    bus.r_valid = rv;
    bus.r_addr  = rad;
    @(negedge clock);
    wacc = wv && bus.w_ready;
    racc = rv && bus.r_ready;
    @(posedge clock);
    #1;
    bus.w_valid = 1'b0;
    bus.r_valid = 1'b0;
  endtask

  task automatic count_sweep(output int n, output logic [AW-1:0] first_addr);
    n = 0;
    @(negedge clock);
    first_addr = bus.sram_addr;
    while (!bus.init_done && n < 5000) begin
      n++;
      @(negedge clock);
    end
    @(posedge clock);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  localparam logic [DW-1:0] D1 = 60'hABCDEF012345678;
  localparam logic [DW-1:0] D2 = 60'h123456789ABCDEF;

  initial begin
    bit            wa, ra;
    int            n;
    logic [AW-1:0] fa;
    bus.w_valid = 1'b0; bus.w_addr = '0; bus.w_mask = '0; bus.w_data = '0;
    bus.r_valid = 1'b0; bus.r_addr = '0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;

    // interrupt the sweep as it is about to write address 1000
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!(bus.sram_en && bus.sram_addr == 12'd999) && n < 2000);
    chk("sweep_reach_999", 64'(n), 64'd1000);
    @(posedge clock); #1 reset = 1'b1;
    @(posedge clock); #1 reset = 1'b0;
    count_sweep(n, fa);
    chk("sweep_len_after_reset", 64'(n), 64'd4096);
    chk("sweep_restart_addr", 64'(fa), 64'd0);

    // full write then read back, then hold across idle cycles
    step(1, 12'h005, 10'h3FF, D1, 0, '0, wa, ra);
    chk("wr1_accept", 64'(wa), 64'd1);
    step(0, '0, '0, '0, 1, 12'h005, wa, ra);
    chk("rd1_accept", 64'(ra), 64'd1);
    @(negedge clock);
    chk("rd1_resp_valid", 64'(bus.resp_valid), 64'd1);
    chk("rd1_resp_data", 64'(bus.resp_data), 64'(D1));
    repeat (10) @(posedge clock);
    @(negedge clock);
    chk("rd1_hold_valid", 64'(bus.resp_valid), 64'd0);
    chk("rd1_hold_data", 64'(bus.resp_data), 64'(D1));
    @(posedge clock); #1;

    // single-lane write over a zero word
    step(1, 12'h005, 10'h3FF, '0, 0, '0, wa, ra);
    step(1, 12'h005, 10'h001, '1, 0, '0, wa, ra);
    step(0, '0, '0, '0, 1, 12'h005, wa, ra);
    @(negedge clock);
    chk("lane0_resp", 64'(bus.resp_data), 64'h3F);
    @(posedge clock); #1;

`ifdef SRAM_RW_CTRL_WBUF_EN
    // buffered partial write merged into a read that hits it
    step(1, 12'h010, 10'h3FF, D2, 0, '0, wa, ra);
    step(1, 12'h010, 10'h002, 60'hFC0, 1, 12'h011, wa, ra);
    chk("wbuf_both_w", 64'(wa), 64'd1);
    chk("wbuf_both_r", 64'(ra), 64'd1);
    step(0, '0, '0, '0, 1, 12'h010, wa, ra);
    @(negedge clock);
    chk("wbuf_merge_valid", 64'(bus.resp_valid), 64'd1);
    chk("wbuf_merge_data", 64'(bus.resp_data), 64'h123456789ABCFEF);
    chk("wbuf_drain_en", 64'(bus.sram_en && bus.sram_wmode), 64'd1);
    @(posedge clock); #1;
    step(0, '0, '0, '0, 1, 12'h010, wa, ra);
    @(negedge clock);
    chk("wbuf_after_drain", 64'(bus.resp_data), 64'h123456789ABCFEF);
    @(posedge clock); #1;
`else
    // simultaneous requests: write wins, read follows
    step(1, 12'h020, 10'h3FF, D2, 1, 12'h005, wa, ra);
    chk("prio_w_accept", 64'(wa), 64'd1);
    chk("prio_r_block", 64'(ra), 64'd0);
    step(0, '0, '0, '0, 1, 12'h005, wa, ra);
    chk("prio_r_retry", 64'(ra), 64'd1);
    @(negedge clock);
    chk("prio_resp_valid", 64'(bus.resp_valid), 64'd1);
    chk("prio_resp_data", 64'(bus.resp_data), 64'h3F);
    @(posedge clock); #1;
`endif

    for (int i = 0; i < 3000; i++) begin
      step(1'($urandom_range(0, 1)), 12'($urandom_range(0, 15)), 10'($urandom()), rnd60(),
           1'($urandom_range(0, 1)), 12'($urandom_range(0, 15)), wa, ra);
    end

    // read in flight when reset hits, then a fresh sweep
    step(0, '0, '0, '0, 1, 12'h003, wa, ra);
    chk("inflight_accept", 64'(ra), 64'd1);
    reset = 1'b1;
    @(posedge clock); #1 reset = 1'b0;
    count_sweep(n, fa);
    chk("sweep_len_2", 64'(n), 64'd4096);
    step(0, '0, '0, '0, 1, 12'h005, wa, ra);
    @(negedge clock);
    chk("post_sweep_zero", 64'(bus.resp_data), 64'd0);
    @(posedge clock); #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
